mux_tree_tapbuf_ccff_bank: RTL and testbench
============================================

# mux_tree_tapbuf_ccff_bank

Parametrised bank of configurable routing multiplexers with an integrated configuration shift chain and a shadow select register. Each of `NUM_CH` output channels selects one of `NUM_IN` shared inputs, or a constant 1 pad. Select codes are loaded serially through a ccff chain and applied atomically on commit, so routing never glitches while the chain shifts. The block sits in connection and switch blocks and cascades with other chain segments through `ccff_head` and `ccff_tail`.

## Interface
- `NUM_IN`, default 11: number of shared data inputs, minimum 2.
- `NUM_CH`, default 2: number of independent output channels, minimum 1.
- `SEL_W`, default `$clog2(NUM_IN+1)`: select code width per channel. It must satisfy `2**SEL_W > NUM_IN`.
- `CHAIN_LEN`, default `NUM_CH*SEL_W`: derived length of the configuration chain. Do not override.
- `prog_clk`, input, 1: the single clock. All state is updated on its rising edge.
- `pReset`, input, 1: reset, asynchronous and active-high.
- `in`, input, `NUM_IN`: shared data inputs.
- `ccff_head`, input, 1: serial configuration data in.
- `cfg_shift`, input, 1: shifts the chain by one bit this cycle.
- `cfg_commit`, input, 1: requests a copy of the chain into the shadow register.
- `out`, output, `NUM_CH`: routed outputs, one per channel.
- `ccff_tail`, output, 1: serial configuration data out, equal to the chain MSB.
- `cfg_valid`, output, 1: level signal, high once at least one commit has been accepted since reset.
- `cfg_err`, output, 1: one-cycle pulse when a commit is rejected.

## Operation
- Chain `C[CHAIN_LEN-1:0]`: when `cfg_shift`=1, `C <= {C[CHAIN_LEN-2:0], ccff_head}`. `ccff_tail = C[CHAIN_LEN-1]`.
- Channel k's pending code is `C[k*SEL_W +: SEL_W]`. The first bit shifted in ends up at the MSB of channel `NUM_CH-1`.
- Shadow register `S` holds the active codes and drives the mux select. Only an accepted commit changes `S`.
- Decode per channel: a code c with c < `NUM_IN` selects `in[c]`. A code c with c ≥ `NUM_IN` selects constant 1.
- Shift counter `cnt`, width `$clog2(CHAIN_LEN+2)`:
  - increments on each shift;
  - saturates at `CHAIN_LEN+1`;
  - clears to 0 on an accepted commit.
- Commit is accepted only if `cnt == CHAIN_LEN`. On acceptance: `S <= C`, `cnt <= 0` (or 1 if `cfg_shift` is also high that cycle), `cfg_valid <= 1`.
- Commit with `cnt != CHAIN_LEN`, including an overshifted chain:
  - `S` is unchanged;
  - `cnt` is unchanged apart from a concurrent shift;
  - `cfg_err` pulses high for one cycle.
- Shift and commit in the same cycle: the commit checks the pre-shift `cnt` and captures the pre-shift `C`. The shift still takes effect.
- Reset values:
  - `C` = all zeros;
  - `S` = all ones, so every channel selects constant 1 and `out` = all ones;
  - `cnt` = 0;
  - `cfg_valid` = 0, `cfg_err` = 0;
  - `ccff_tail` = 0.
- A reset in mid-shift discards all partial configuration. It takes effect immediately and asynchronously.

## Timing
- `ccff_tail` follows `ccff_head` with a latency of exactly `CHAIN_LEN` shift cycles.
- An accepted commit changes the active code one edge after `cfg_commit` is sampled. `out` then follows as set by the macro below.
- `cfg_err` is registered. It is high during the cycle after the rejected commit is sampled.
- `in` to `out` is combinational unless the output register is compiled in.

## Configuration
- `MUX_OUT_REG_EN` defined:
  - each `out[k]` is registered on `prog_clk`, giving a latency of 1 cycle from `in` or a code change to `out`;
  - the register resets to 1.
- `MUX_OUT_REG_EN` undefined: `out` is a purely combinational function of `in` and `S`, with no added latency.

## Test plan
- Reset, then release: `out`=2'b11, `cfg_valid`=0, `ccff_tail`=0, with no commit issued.
- Defaults (`NUM_IN`=11, `NUM_CH`=2, `SEL_W`=4). Shift bits 1,0,1,0,0,0,1,1, then commit:
  - `cfg_valid`=1;
  - `out[0]` tracks `in[3]`;
  - `out[1]` tracks `in[10]`;
  - toggling `in[3]` and `in[10]` appears on `out`.
- Shift 8 bits so that ch0=11 and ch1=15, then commit: `out`=2'b11 regardless of `in`, confirming the const1 pad for out-of-range codes.
- Shift 7 bits, then commit: `cfg_err` pulses for 1 cycle and `out` is unchanged. Shift 9 bits, then commit: `cfg_err` pulses again.
- Assert shift and commit together when `cnt`=8: the pre-shift codes are applied, `cnt` becomes 1, and after 7 more shifts a commit is accepted.
- Pass a pattern through: `ccff_tail` echoes `ccff_head` after 8 shifts. Assert `pReset` mid-sequence: `out` returns to all ones asynchronously and `cnt`=0.

Source files
------------

// File: rtl/mux_tree_tapbuf_ccff_bank.sv
// mux_tree_tapbuf_ccff_bank: a bank of routing multiplexers. Each channel picks one
// shared input, or a constant-1 pad when its select code is NUM_IN or larger.
// Select codes are loaded serially through a ccff shift chain. A counted commit then
// copies them atomically into a shadow register, so routing never glitches while the
// chain shifts.
// Optional feature: define MUX_OUT_REG_EN to register each channel output on prog_clk.
// The output register resets to 1.
module mux_tree_tapbuf_ccff_bank #(
  parameter int unsigned NUM_IN    = 11,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned SEL_W     = $clog2(NUM_IN + 1),
  parameter int unsigned CHAIN_LEN = NUM_CH * SEL_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic [NUM_IN-1:0] in,
  input  logic              ccff_head,
  input  logic              cfg_shift,
  input  logic              cfg_commit,
  output logic [NUM_CH-1:0] out,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  // Configuration state
  logic [CHAIN_LEN-1:0] chain_q,  chain_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic                 valid_q,  valid_d;
  logic                 err_q,    err_d;
  logic                 commit_ok_c;

  // Decoded mux outputs, before the optional output register
  logic [NUM_CH-1:0]    mux_c;
  logic [SEL_W-1:0]     sel_c;

  // A commit is honoured only when exactly one full chain's worth of bits has been shifted.
  // It checks the pre-shift count and captures the pre-shift chain.
  always_comb begin
    chain_d     = chain_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    commit_ok_c = cfg_commit && (cnt_q == CNT_FULL);

    if (cfg_shift) begin
      chain_d = {chain_q[CHAIN_LEN-2:0], ccff_head};
    end

    if (commit_ok_c) begin
      shadow_d = chain_q;
      valid_d  = 1'b1;
      cnt_d    = cfg_shift ? CNT_W'(1) : CNT_W'(0);
    end else begin
      if (cfg_shift && (cnt_q != CNT_SAT)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cfg_commit) begin
        err_d = 1'b1;
      end
    end
  end

  // Configuration registers. Reset discards any partially shifted configuration.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      chain_q  <= '0;
      shadow_q <= '1;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Per-channel decode: an in-range code picks in[code]; any other code falls through to constant 1.
  always_comb begin
    mux_c = '1;
    sel_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sel_c = shadow_q[k*SEL_W +: SEL_W];
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (sel_c == SEL_W'(i)) begin
          mux_c[k] = in[i];
        end
      end
    end
  end

`ifdef MUX_OUT_REG_EN
  logic [NUM_CH-1:0] out_q;

  // Output retiming register. It reads as constant 1 out of reset.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      out_q <= '1;
    end else begin
      out_q <= mux_c;
    end
  end

  assign out = out_q;
`else
  assign out = mux_c;
`endif

  assign ccff_tail = chain_q[CHAIN_LEN-1];
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_mux_tree_tapbuf_ccff_bank.sv
// Directed bench for mux_tree_tapbuf_ccff_bank with the default parameters (11 inputs,
// 2 channels, 4-bit codes, 8-bit chain). The output register is not compiled in.
module tb_mux_tree_tapbuf_ccff_bank;

  logic        prog_clk = 1'b0;
  logic        pReset   = 1'b1;
  logic [10:0] in       = '0;
  logic        ccff_head  = 1'b0;
  logic        cfg_shift  = 1'b0;
  logic        cfg_commit = 1'b0;
  logic [1:0]  out;
  logic        ccff_tail;
  logic        cfg_valid;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  mux_tree_tapbuf_ccff_bank dut (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .in         (in),
    .ccff_head  (ccff_head),
    .cfg_shift  (cfg_shift),
    .cfg_commit (cfg_commit),
    .out        (out),
    .ccff_tail  (ccff_tail),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    string       name;
    logic [7:0]  cfg;   // shifted MSB first: cfg[7:4] = ch1 code, cfg[3:0] = ch0 code
    logic [10:0] din;
    logic [1:0]  exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    ccff_head = b;
    cfg_shift = 1'b1;
    tick();
    cfg_shift = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) shift_bit(b[i]);
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  logic [7:0]  model_chain;
  logic [11:0] pat;

  initial begin
    vecs[0] = '{"a3_in3",     8'hA3, 11'h008, 2'b01};
    vecs[1] = '{"a3_in10",    8'hA3, 11'h400, 2'b10};
    vecs[2] = '{"a3_both",    8'hA3, 11'h408, 2'b11};
    vecs[3] = '{"a3_others",  8'hA3, 11'h3F7, 2'b00};
    vecs[4] = '{"fb_const1",  8'hFB, 11'h000, 2'b11};
    vecs[5] = '{"10_in0",     8'h10, 11'h001, 2'b01};
    vecs[6] = '{"10_in1",     8'h10, 11'h002, 2'b10};
    vecs[7] = '{"a5_in5",     8'hA5, 11'h020, 2'b01};
    vecs[8] = '{"b0_ch1pad",  8'hB0, 11'h000, 2'b10};

    // Reset state, checked both while reset is held and after it is released
    tick(); tick();
    check("rst_out",   32'(out), 32'h3);
    check("rst_valid", 32'(cfg_valid), 32'h0);
    check("rst_tail",  32'(ccff_tail), 32'h0);
    pReset = 1'b0;
    in = 11'h7FF;
    tick();
    in = 11'h000;
    #1;
    check("post_rst_out",   32'(out), 32'h3);
    check("post_rst_valid", 32'(cfg_valid), 32'h0);
    check("post_rst_err",   32'(cfg_err), 32'h0);

    // Table-driven configurations and input patterns
    for (int v = 0; v < 9; v++) begin
      shift_byte(vecs[v].cfg);
      commit();
      check({vecs[v].name, "_err"},   32'(cfg_err), 32'h0);
      check({vecs[v].name, "_valid"}, 32'(cfg_valid), 32'h1);
      in = vecs[v].din;
      #1;
      check({vecs[v].name, "_out"}, 32'(out), 32'(vecs[v].exp));
    end

    // Undershift: a commit after 7 bits is rejected and the B0 routing stays active
    in = 11'h000;
    for (int i = 0; i < 7; i++) shift_bit(1'b0);
    commit();
    check("under_err_pulse", 32'(cfg_err), 32'h1);
    check("under_out_kept",  32'(out), 32'h2);
    tick();
    check("under_err_clear", 32'(cfg_err), 32'h0);

    // Overshift: the count saturates past a full chain and the commit is rejected again
    for (int i = 0; i < 9; i++) shift_bit(1'b0);
    commit();
    check("over_err_pulse", 32'(cfg_err), 32'h1);
    check("over_out_kept",  32'(out), 32'h2);
    tick();
    check("over_err_clear", 32'(cfg_err), 32'h0);

    // A reset is the only way back from an overshifted count
    pReset = 1'b1;
    #1;
    check("rst2_out",   32'(out), 32'h3);
    check("rst2_valid", 32'(cfg_valid), 32'h0);
    tick();
    pReset = 1'b0;

    // Shift and commit together: the pre-shift code A3 is applied, the new bit enters the chain
    shift_byte(8'hA3);
    ccff_head  = 1'b0;
    cfg_shift  = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_shift  = 1'b0;
    cfg_commit = 1'b0;
    check("combo_err",   32'(cfg_err), 32'h0);
    check("combo_valid", 32'(cfg_valid), 32'h1);
    in = 11'h408;
    #1;
    check("combo_out_a3", 32'(out), 32'h3);
    // Seven more bits complete 8'h10; the count restarted at 1, so this commit is accepted
    for (int i = 6; i >= 0; i--) shift_bit(i == 4);
    commit();
    check("combo2_err", 32'(cfg_err), 32'h0);
    check("combo2_out_408", 32'(out), 32'h0);
    in = 11'h003;
    #1;
    check("combo2_out_003", 32'(out), 32'h3);

    // Serial pass-through: the tail is the bit shifted in eight shifts earlier
    model_chain = 8'h10;
    pat = 12'hB4D;
    for (int i = 11; i >= 0; i--) begin
      shift_bit(pat[i]);
      model_chain = {model_chain[6:0], pat[i]};
      check($sformatf("tail_%0d", 11 - i), 32'(ccff_tail), 32'(model_chain[7]));
    end

    // Asynchronous reset in the middle of shifting, asserted between clock edges
    ccff_head = 1'b1;
    cfg_shift = 1'b1;
    tick();
    #3;
    pReset = 1'b1;
    #1;
    check("async_out",   32'(out), 32'h3);
    check("async_tail",  32'(ccff_tail), 32'h0);
    check("async_valid", 32'(cfg_valid), 32'h0);
    tick();
    cfg_shift = 1'b0;
    pReset    = 1'b0;
    tick();

    // The count restarted at 0: exactly eight shifts then a commit are accepted
    in = 11'h008;
    shift_byte(8'hA3);
    commit();
    check("after_async_err",   32'(cfg_err), 32'h0);
    check("after_async_valid", 32'(cfg_valid), 32'h1);
    check("after_async_out",   32'(out), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
